// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game sequencer.
//   state_t     : top-level game phase encoding
//   ROUND_W     : width of the play FSM round count
//   TMR_W       : width of the tick timers and the inactivity counter
//   DEF_LIVES   : default number of misses allowed per game
//   rounds_done : rounds completed when the play FSM reports a round number
package simon_pkg;

  localparam int ROUND_W   = 4;
  localparam int TMR_W     = 8;
  localparam int DEF_LIVES = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PLAY    = 3'd2,
    PENALTY = 3'd3,
    WIN     = 3'd4,
    OVER    = 3'd5
  } state_t;

  // The play FSM reports the round it is on, so the completed count is one
  // less. Round 0 (FSM not yet started) counts as nothing completed.
  function automatic logic [ROUND_W-1:0] rounds_done(input logic [ROUND_W-1:0] r);
    return (r == '0) ? '0 : r - 1'b1;
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Link between the game sequencer, the sequence loader and the play FSM.
//   master : sequencer side (drives loader_start, fsm_hold, start_play)
//   slave  : loader / play FSM side (drives loader_done, fsm_error,
//            fsm_round, btn_valid)
interface simon_game_ctrl_if;
  import simon_pkg::*;

  logic               loader_start;
  logic               loader_done;
  logic               fsm_error;
  logic [ROUND_W-1:0] fsm_round;
  logic               btn_valid;
  logic               fsm_hold;
  logic               start_play;

  modport master (
    output loader_start, fsm_hold, start_play,
    input  loader_done, fsm_error, fsm_round, btn_valid
  );

  modport slave (
    input  loader_start, fsm_hold, start_play,
    output loader_done, fsm_error, fsm_round, btn_valid
  );

endinterface

// File: rtl/simon_tick_timer.sv
// Loadable tick down-counter.
//   clk_tick : game tick clock
//   reset    : asynchronous, active-high
//   load     : load the counter with value (wins over en)
//   value    : interval length in ticks
//   en       : count down one per tick while nonzero
//   expired  : high during the last tick of the loaded interval, so the
//              owning state can leave on the edge that ends it
module simon_tick_timer
  import simon_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_tick,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= value;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt <= W'(1));

endmodule

// File: rtl/simon_game_ctrl.sv
// Top-level Simon game sequencer, clocked by the ~1 Hz tick.
//   clk_tick, reset : tick clock, asynchronous active-high reset
//   start_btn       : synchronized start level (rising edge starts a game)
//   bus (master)    : loader_start/loader_done to the sequence loader;
//                     fsm_hold/start_play to, fsm_error/fsm_round/btn_valid
//                     from the play FSM
//   lives           : remaining lives
//   win_led         : game won
//   game_over       : lives exhausted or load fault
//   load_fault      : loader did not finish within LOAD_TMO ticks
//   best_score      : best completed round count since reset
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int N             = 10,
  parameter int LIVES         = DEF_LIVES,
  parameter int TIMEOUT_TICKS = 8,
  parameter int PENALTY_TICKS = 3,
  parameter int LOAD_TMO      = 32
) (
  input  logic               clk_tick,
  input  logic               reset,
  input  logic               start_btn,
  simon_game_ctrl_if.master  bus,
  output logic [1:0]         lives,
  output logic               win_led,
  output logic               game_over,
  output logic               load_fault,
  output logic [ROUND_W-1:0] best_score
);

  localparam logic [ROUND_W-1:0] WIN_ROUND  = ROUND_W'(N + 1);
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
  localparam logic [TMR_W-1:0]   LOAD_V     = TMR_W'(LOAD_TMO);
  localparam logic [TMR_W-1:0]   PEN_V      = TMR_W'(PENALTY_TICKS);
  localparam logic [TMR_W:0]     TO_V       = (TMR_W+1)'(TIMEOUT_TICKS);

  state_t             state, state_nx;
  logic               start_q, err_q;
  logic [ROUND_W-1:0] round_q;
  logic [TMR_W-1:0]   idle_cnt, idle_nx, idle_inc;
  logic [TMR_W:0]     idle_thr;
  logic               start_edge, err_edge, idle_clr, timeout, miss;
  logic [ROUND_W-1:0] best_up;

  logic               hold_q, play_q, ld_start_q;
  logic               ld_start_nx, win_nx, over_nx, fault_nx;
  logic [1:0]         lives_nx;
  logic [ROUND_W-1:0] best_nx;

  logic               tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0]   tmr_val;

  // Load timeout and penalty never overlap, so one timer serves both.
  simon_tick_timer #(.W(TMR_W)) u_tmr (
    .clk_tick (clk_tick),
    .reset    (reset),
    .load     (tmr_load),
    .value    (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  assign tmr_en     = (state == LOAD) || (state == PENALTY);
  assign start_edge = start_btn & ~start_q;
  assign err_edge   = bus.fsm_error & ~err_q;

  // Inactivity: any press or round advance restarts the count. The limit
  // grows with the round number to leave room for sequence playback.
  assign idle_clr = bus.btn_valid || (bus.fsm_round != round_q);
  assign idle_inc = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;
  assign idle_thr = {{(TMR_W+1-ROUND_W){1'b0}}, bus.fsm_round} + TO_V;
  assign timeout  = !idle_clr && ({1'b0, idle_inc} >= idle_thr);
  assign miss     = err_edge || timeout;

  assign best_up = (rounds_done(bus.fsm_round) > best_score) ?
                   rounds_done(bus.fsm_round) : best_score;

  always_comb begin
    state_nx    = state;
    lives_nx    = lives;
    win_nx      = win_led;
    over_nx     = game_over;
    fault_nx    = load_fault;
    best_nx     = best_score;
    ld_start_nx = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = LOAD_V;
    idle_nx     = '0;
    case (state)
      IDLE, WIN, OVER: begin
        if (start_edge) begin
          state_nx    = LOAD;
          ld_start_nx = 1'b1;
          lives_nx    = LIVES_INIT;
          win_nx      = 1'b0;
          over_nx     = 1'b0;
          fault_nx    = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = LOAD_V;
        end
      end
      LOAD: begin
        if (bus.loader_done) begin
          state_nx = PLAY;
        end else if (tmr_expired) begin
          state_nx = OVER;
          fault_nx = 1'b1;
          over_nx  = 1'b1;
        end
      end
      PLAY: begin
        idle_nx = idle_clr ? '0 : idle_inc;
        // A miss outranks a win landing on the same tick.
        if (miss) begin
          best_nx  = best_up;
          lives_nx = lives - 2'd1;
          if (lives == 2'd1) begin
            state_nx = OVER;
            over_nx  = 1'b1;
          end else begin
            state_nx = PENALTY;
            tmr_load = 1'b1;
            tmr_val  = PEN_V;
          end
        end else if (bus.fsm_round == WIN_ROUND) begin
          state_nx = WIN;
          win_nx   = 1'b1;
          best_nx  = best_up;
        end
      end
      PENALTY: begin
        if (tmr_expired) state_nx = PLAY;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      round_q    <= '0;
      idle_cnt   <= '0;
      hold_q     <= 1'b1;
      play_q     <= 1'b0;
      ld_start_q <= 1'b0;
      lives      <= 2'd0;
      win_led    <= 1'b0;
      game_over  <= 1'b0;
      load_fault <= 1'b0;
      best_score <= '0;
    end else begin
      state      <= state_nx;
      start_q    <= start_btn;
      err_q      <= bus.fsm_error;
      round_q    <= bus.fsm_round;
      idle_cnt   <= idle_nx;
      // Hold comes off a flop driven by the next state, so it rises on the
      // very edge that leaves PLAY and never glitches.
      hold_q     <= (state_nx != PLAY);
      play_q     <= (state_nx == PLAY);
      ld_start_q <= ld_start_nx;
      lives      <= lives_nx;
      win_led    <= win_nx;
      game_over  <= over_nx;
      load_fault <= fault_nx;
      best_score <= best_nx;
    end
  end

  assign bus.fsm_hold     = hold_q;
  assign bus.start_play   = play_q;
  assign bus.loader_start = ld_start_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural game model.
module tb_simon_game_ctrl;
  import simon_pkg::*;

  localparam int N_R  = 10;
  localparam int LV   = 3;
  localparam int TO   = 8;
  localparam int PEN  = 3;
  localparam int LTMO = 32;

  logic       clk_tick = 1'b0;
  logic       reset    = 1'b1;
  logic       start_btn = 1'b0;
  logic [1:0] lives;
  logic       win_led, game_over, load_fault;
  logic [3:0] best_score;

  simon_game_ctrl_if bus();

  simon_game_ctrl #(
    .N(N_R), .LIVES(LV), .TIMEOUT_TICKS(TO), .PENALTY_TICKS(PEN), .LOAD_TMO(LTMO)
  ) dut (
    .clk_tick   (clk_tick),
    .reset      (reset),
    .start_btn  (start_btn),
    .bus        (bus),
    .lives      (lives),
    .win_led    (win_led),
    .game_over  (game_over),
    .load_fault (load_fault),
    .best_score (best_score)
  );

  always #5 clk_tick = ~clk_tick;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model: game phase as a word, counters counting up.
  string ph;
  int    e_lives, e_best, load_ticks, quiet, pen_left;
  bit    e_ls, e_win, e_go, e_lf;
  bit    m_start_q, m_err_q;
  int    m_round_q;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = "idle"; e_lives = 0; e_best = 0; e_ls = 0; e_win = 0; e_go = 0; e_lf = 0;
    load_ticks = 0; quiet = 0; pen_left = 0;
    m_start_q = 0; m_err_q = 0; m_round_q = 0;
  endtask

  task automatic model_step();
    bit se, ee, rc, tout;
    int rnd, rd;
    rnd  = int'(bus.fsm_round);
    se   = start_btn && !m_start_q;
    ee   = bus.fsm_error && !m_err_q;
    rc   = (rnd != m_round_q);
    tout = 0;
    e_ls = 0;
    if (ph == "idle" || ph == "win" || ph == "over") begin
      if (se) begin
        ph = "load"; e_ls = 1; e_lives = LV; e_win = 0; e_go = 0; e_lf = 0; load_ticks = 0;
      end
    end else if (ph == "load") begin
      load_ticks++;
      if (bus.loader_done) begin
        ph = "play"; quiet = 0;
      end else if (load_ticks >= LTMO) begin
        ph = "over"; e_lf = 1; e_go = 1;
      end
    end else if (ph == "play") begin
      if (bus.btn_valid || rc) quiet = 0;
      else begin
        if (quiet < 255) quiet++;
        tout = (quiet >= rnd + TO);
      end
      rd = (rnd == 0) ? 0 : rnd - 1;
      if (ee || tout) begin
        if (rd > e_best) e_best = rd;
        e_lives--;
        if (e_lives == 0) begin ph = "over"; e_go = 1; end
        else begin ph = "pen"; pen_left = PEN; end
      end else if (rnd == N_R + 1) begin
        if (rd > e_best) e_best = rd;
        e_win = 1; ph = "win";
      end
    end else if (ph == "pen") begin
      pen_left--;
      if (pen_left == 0) begin ph = "play"; quiet = 0; end
    end
    m_start_q = start_btn;
    m_err_q   = bus.fsm_error;
    m_round_q = rnd;
  endtask

  task automatic compare_all();
    check("loader_start", int'(bus.loader_start), int'(e_ls));
    check("fsm_hold",     int'(bus.fsm_hold),     int'(ph != "play"));
    check("start_play",   int'(bus.start_play),   int'(ph == "play"));
    check("lives",        int'(lives),            e_lives);
    check("win_led",      int'(win_led),          int'(e_win));
    check("game_over",    int'(game_over),        int'(e_go));
    check("load_fault",   int'(load_fault),       int'(e_lf));
    check("best_score",   int'(best_score),       e_best);
  endtask

  // One tick: model follows the edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk_tick);
    if (!reset) model_step();
    @(negedge clk_tick);
    if (chk_en) compare_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all();
    check("rst_hold",  int'(bus.fsm_hold), 1);
    check("rst_lives", int'(lives), 0);
    check("rst_best",  int'(best_score), 0);
    @(negedge clk_tick);
    @(negedge clk_tick);
    reset = 1'b0;
  endtask

  initial begin
    int p;
    bus.loader_done = 0; bus.fsm_error = 0; bus.fsm_round = '0; bus.btn_valid = 0;
    model_reset();
    @(negedge clk_tick);
    chk_en = 1'b1;
    compare_all();
    check("reset_hold", int'(bus.fsm_hold), 1);
    check("reset_play", int'(bus.start_play), 0);
    @(negedge clk_tick);
    reset = 1'b0;

    // Start, loader finishes 4 ticks later.
    start_btn = 1; tick();
    check("start_pulse", int'(bus.loader_start), 1);
    check("start_lives", int'(lives), 3);
    start_btn = 0; tick();
    check("pulse_one_tick", int'(bus.loader_start), 0);
    tick(); tick();
    bus.loader_done = 1; tick();
    check("play_after_done", int'(bus.start_play), 1);
    check("hold_released", int'(bus.fsm_hold), 0);

    // Error at round 3 -> penalty of 3 ticks.
    bus.fsm_round = 4'd3; tick();
    bus.fsm_error = 1; tick();
    check("err_lives", int'(lives), 2);
    check("err_best", int'(best_score), 2);
    check("err_hold", int'(bus.fsm_hold), 1);
    bus.fsm_error = 0; bus.fsm_round = 4'd2;
    tick(); check("pen_hold1", int'(bus.fsm_hold), 1);
    tick(); check("pen_hold2", int'(bus.fsm_hold), 1);
    tick(); check("pen_release", int'(bus.fsm_hold), 0);

    // Silence at round 2: miss on the 10th tick after PLAY entry.
    for (int j = 1; j <= 9; j++) begin
      tick(); check("quiet_play", int'(bus.start_play), 1);
    end
    tick();
    check("timeout_miss", int'(bus.start_play), 0);
    check("timeout_lives", int'(lives), 1);
    tick(); tick(); tick();
    check("pen2_release", int'(bus.start_play), 1);

    // A press on tick 9 restarts the count.
    for (int j = 1; j <= 8; j++) tick();
    bus.btn_valid = 1; tick();
    bus.btn_valid = 0; tick();
    check("btn_saves", int'(bus.start_play), 1);

    // Third miss ends the game.
    bus.fsm_error = 1; tick();
    check("over_flag", int'(game_over), 1);
    check("over_lives", int'(lives), 0);
    check("over_hold", int'(bus.fsm_hold), 1);
    bus.fsm_error = 0;
    start_btn = 1; tick();
    check("restart_lives", int'(lives), 3);
    check("restart_over", int'(game_over), 0);
    start_btn = 0; bus.fsm_round = 4'd1; tick();

    // Climb to round N+1 -> win.
    for (int r = 2; r <= 11; r++) begin
      bus.fsm_round = 4'(r); tick();
    end
    check("win_led", int'(win_led), 1);
    check("win_best", int'(best_score), 10);

    // New game; error coinciding with the winning round change is a miss.
    start_btn = 1; bus.fsm_round = 4'd1; tick();
    check("win_cleared", int'(win_led), 0);
    start_btn = 0; tick();
    for (int r = 2; r <= 10; r++) begin
      bus.fsm_round = 4'(r); tick();
    end
    bus.fsm_round = 4'd11; bus.fsm_error = 1; tick();
    check("miss_over_win", int'(win_led), 0);
    check("miss_over_win_lives", int'(lives), 2);
    bus.fsm_error = 0; bus.fsm_round = 4'd1;
    tick(); tick(); tick();
    check("back_in_play", int'(bus.start_play), 1);

    // Asynchronous reset mid-PLAY.
    bus.loader_done = 0; bus.fsm_round = '0;
    async_reset();

    // Loader never finishes -> fault 32 ticks after the start pulse.
    start_btn = 1; tick();
    check("lf_pulse", int'(bus.loader_start), 1);
    start_btn = 0;
    for (int k = 1; k <= 31; k++) tick();
    check("lf_not_yet", int'(load_fault), 0);
    tick();
    check("lf_set", int'(load_fault), 1);
    check("lf_over", int'(game_over), 1);

    // Randomized play.
    p = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) p = (i % 600 == 0) ? 20 : ((i % 400 == 0) ? 2 : 4);
      if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 5) == 0) bus.loader_done = ~bus.loader_done;
      bus.fsm_error = ($urandom_range(0, 29) == 0);
      bus.btn_valid = ($urandom_range(0, p - 1) == 0);
      if ($urandom_range(0, 49) == 0) bus.fsm_round = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0)
        bus.fsm_round = (ph != "play") ? 4'd1 :
                        ((bus.fsm_round >= 4'd11) ? 4'd11 : bus.fsm_round + 4'd1);
      if ($urandom_range(0, 399) == 0) async_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
